// File: rtl/adder12s_frame_ctrl.sv
// Front end for the 8-input signed adder tree: packs serial samples into frames,
// launches them under FIFO credit, and returns tree sums on a valid/ready stream.
module adder12s_frame_ctrl #(
  parameter int W     = 12,
  parameter int LAT   = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_data,
  input  logic             frm_clr,
  output logic [8*W-1:0]   n_bus,
  input  logic [W+2:0]     sum_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W+2:0]     m_sum,
  output logic [W-1:0]     m_mean
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 2);
  localparam int OW = $clog2(LAT + DEPTH + 2);

  logic [2:0]              fill;
  logic [6:0][W-1:0]       slot;
  logic [LAT:0]            vld_pipe;
  logic [DEPTH-1:0][W+2:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           infl;
  logic [OW-1:0]           occ;
  logic                    credit, xfer, launch, push, pop;

  always_comb begin
    infl = '0;
    for (int i = 0; i <= LAT; i++) infl = infl + IW'(vld_pipe[i]);
  end

  // Frames in the tree count against the FIFO because the tree cannot be stalled.
  assign occ     = OW'(infl) + OW'(cnt);
  assign credit  = occ < OW'(DEPTH);
  assign s_ready = !(fill == 3'd7 && !credit);
  assign xfer    = s_valid & s_ready;
  assign launch  = xfer & (fill == 3'd7) & ~frm_clr;
  assign push    = vld_pipe[LAT];
  assign pop     = m_valid & m_ready;

  assign m_valid = (cnt != '0);
  assign m_sum   = mem[rd_ptr];
  assign m_mean  = m_sum[W+2:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill     <= '0;
      slot     <= '0;
      n_bus    <= '0;
      vld_pipe <= '0;
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (frm_clr) begin
        fill <= '0;
      end else if (xfer) begin
        fill <= fill + 3'd1;
        if (fill != 3'd7) slot[fill] <= s_data;
      end
      // Last sample goes straight to n7 so the whole frame lands in one edge.
      if (launch) n_bus <= {s_data, slot};
      vld_pipe <= {vld_pipe[LAT-1:0], launch};

      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) begin
        mem[wr_ptr] <= sum_in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
